// File: rtl/instr_fetch.sv
// Instruction fetch stage: turns PC writes into instruction-memory reads and presents results to decode.
// Latency: pc_update to instr_valid is 2 cycles minimum (ack in first REQ cycle); faults are presented 1 cycle after pc_update.
// Backpressure: the entry holds while instr_ready is low; PC updates arriving meanwhile collapse into one pending slot.
// Build option: define IFETCH_RANGE_CHECK_EN to fault aligned addresses outside the instruction window (cause 10).
module instr_fetch #(
  parameter logic [31:0] IMEM_BASE   = 32'h0100_0000,
  parameter int unsigned IMEM_WORDS  = 1024,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_addr,
  input  logic        pc_update,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause,
  output logic        busy
);

  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE    = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

`ifdef IFETCH_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  // 33-bit bounds so a window ending at the top of the address space cannot wrap
  localparam logic [32:0] WIN_LO = {1'b0, IMEM_BASE};
  localparam logic [32:0] WIN_HI = {1'b0, IMEM_BASE} + 33'(IMEM_WORDS) * 33'd4;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t        state;
  logic          pend_vld;
  logic [31:0]   pend_addr;
  logic [CW-1:0] cnt;

  logic          launch;
  logic [31:0]   launch_addr;
  logic [1:0]    launch_cause;
  logic [32:0]   launch_ext;
  logic          in_window;

  // pick the address to start on this edge: a fresh PC in IDLE wins over a leftover pending one
  always_comb begin
    launch      = 1'b0;
    launch_addr = pc_addr;
    case (state)
      IDLE: begin
        if (pc_update) begin
          launch      = 1'b1;
          launch_addr = pc_addr;
        end else if (pend_vld) begin
          launch      = 1'b1;
          launch_addr = pend_addr;
        end
      end
      HOLD: begin
        if (instr_ready && pend_vld) begin
          launch      = 1'b1;
          launch_addr = pend_addr;
        end
      end
      default: ;
    endcase
  end

  // classify the launch address; misalignment outranks the window check
  always_comb begin
    launch_ext   = {1'b0, launch_addr};
    in_window    = (launch_ext >= WIN_LO) && (launch_ext < WIN_HI);
    launch_cause = CAUSE_NONE;
    if (launch_addr[1:0] != 2'b00) begin
      launch_cause = CAUSE_MISALIGN;
    end else if (RANGE_EN && !in_window) begin
      launch_cause = CAUSE_RANGE;
    end
  end

  // fetch FSM with registered outputs and the one-entry pending slot
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      imem_req    <= 1'b0;
      imem_addr   <= 32'h0;
      instr       <= NOP;
      instr_pc    <= 32'h0;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
      fault_cause <= CAUSE_NONE;
      busy        <= 1'b0;
      pend_vld    <= 1'b0;
      pend_addr   <= 32'h0;
      cnt         <= '0;
    end else begin
      // IDLE always consumes the slot; elsewhere a new PC overwrites it, a handshake consumes it
      if (state == IDLE) begin
        pend_vld <= 1'b0;
      end else if (pc_update) begin
        pend_vld  <= 1'b1;
        pend_addr <= pc_addr;
      end else if (state == HOLD && instr_ready) begin
        pend_vld <= 1'b0;
      end

      if (launch) begin
        busy     <= 1'b1;
        instr_pc <= launch_addr;
        if (launch_cause != CAUSE_NONE) begin
          state       <= HOLD;
          imem_req    <= 1'b0;
          instr       <= NOP;
          instr_valid <= 1'b1;
          fetch_fault <= 1'b1;
          fault_cause <= launch_cause;
        end else begin
          state       <= REQ;
          imem_req    <= 1'b1;
          imem_addr   <= launch_addr;
          cnt         <= '0;
          instr_valid <= 1'b0;
          fetch_fault <= 1'b0;
          fault_cause <= CAUSE_NONE;
        end
      end else begin
        case (state)
          REQ: begin
            if (imem_ack) begin
              state       <= HOLD;
              imem_req    <= 1'b0;
              instr       <= imem_rdata;
              instr_valid <= 1'b1;
              fetch_fault <= 1'b0;
              fault_cause <= CAUSE_NONE;
            end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
              state       <= HOLD;
              imem_req    <= 1'b0;
              instr       <= NOP;
              instr_valid <= 1'b1;
              fetch_fault <= 1'b1;
              fault_cause <= CAUSE_TIMEOUT;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          HOLD: begin
            if (instr_ready) begin
              state       <= IDLE;
              instr_valid <= 1'b0;
              fetch_fault <= 1'b0;
              fault_cause <= CAUSE_NONE;
              busy        <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
